spi_master_multimode: RTL
=========================

Name: spi_master_multimode

Overview:
- Parametrised SPI master that performs an address-then-read transaction against one of N_SS slave selects.
- Shifts out an ADDR_WIDTH-bit address on MOSI, then shifts in a DATA_WIDTH-bit response on MISO and presents it on DATA with a one-cycle DONE pulse.
- Adds over the previous master: an explicit START/BUSY/DONE handshake, a programmable SCLK divider, all four SPI modes (CPOL/CPHA), and out-of-range select detection.
- Sits between the system controller and the shared SCLK/MOSI/MISO bus; slave MISO outputs are OR-combined externally.

Parameters:
N_SS, 4, number of slave-select lines
SS_ADDR_WIDTH, 2, width of SS_ADDR
ADDR_WIDTH, 8, address bits sent per transaction
DATA_WIDTH, 8, data bits received per transaction
CLK_DIV, 4, CLK cycles per SCLK half-period (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
START  input  1  request a transaction; sampled only in IDLE
SS_ADDR  input  SS_ADDR_WIDTH  target slave index
DATA_ADDR  input  ADDR_WIDTH  address to send
CPOL  input  1  SCLK idle level
CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge
BUSY  output  1  high from cycle after START accepted until DONE cycle inclusive
DONE  output  1  one-cycle pulse at transaction end
ERR  output  1  valid with DONE; 1 = SS_ADDR >= N_SS
DATA  output  DATA_WIDTH  last received data, MSB first
SCLK  output  1  serial clock
MOSI  output  1  serial out
MISO  input  1  serial in
SS  output  N_SS  active-low slave selects

Behaviour:
- Reset (synchronous, takes effect on the next CLK edge even mid-transaction): state IDLE, BUSY=0, DONE=0, ERR=0, DATA=0, SCLK=0, MOSI=0, SS all 1, latched mode = 0.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - SCLK = latched CPOL; SS all 1.
  - On START=1, latch SS_ADDR, DATA_ADDR, CPOL and CPHA.
  - If SS_ADDR >= N_SS, go directly to DONE with ERR=1; no SS asserts, no SCLK toggles, DATA unchanged.
  - Otherwise go to SETUP.
- SETUP: SS[sel]=0. MOSI = address MSB. SCLK stays at CPOL for CLK_DIV cycles.
- SHIFT:
  - SCLK toggles every CLK_DIV cycles, giving ADDR_WIDTH+DATA_WIDTH full SCLK periods.
  - Leading edge = transition away from CPOL.
  - CPHA=0: bit driven before the leading edge, sampled on the leading edge, next bit driven on the trailing edge.
  - CPHA=1: bit driven on the leading edge, sampled on the trailing edge.
  - First ADDR_WIDTH bits carry DATA_ADDR MSB first on MOSI; MISO samples taken during these bits are discarded.
  - Remaining DATA_WIDTH bits: MOSI=0; MISO shifted in MSB first.
  - SCLK ends at CPOL level.
- HOLD: SS[sel] stays 0 for CLK_DIV cycles; SCLK at CPOL.
- DONE:
  - SS all 1, MOSI=0, DONE=1 and BUSY=1 for exactly one cycle.
  - DATA updates to the received word in the same cycle DONE rises, and holds until the next successful DONE.
  - Next cycle: IDLE, BUSY=0.
- Latency (valid select): DONE is high on the edge T = CLK_DIV*(2*(ADDR_WIDTH+DATA_WIDTH)+2)+1 edges after the edge that sampled START. Defaults give T = 137.
- Latency (invalid select): DONE on edge 1 after START.
- START while BUSY=1 is ignored, with no queueing. START held high through the DONE cycle is sampled again in IDLE, starting a back-to-back transaction.
- Changes to SS_ADDR, DATA_ADDR, CPOL or CPHA during BUSY have no effect.
- Exactly one SS bit is low at any time, or none.

Test Plan:
1. Defaults, mode 0, slave model on SS[0] returns 8'h41 for address 8'h1A; pulse START with SS_ADDR=0, DATA_ADDR=1A -> MOSI carries 0x1A MSB first, DATA=8'h41, ERR=0, DONE at edge 137, SS[0] low only during SETUP..HOLD.
2. Mode 3 (CPOL=1, CPHA=1), SS_ADDR=2, address 8'h2B, slave returns 8'hB5 -> SCLK idles high before and after, exactly 16 falling/rising pairs, DATA=8'hB5.
3. N_SS=3, SS_ADDR=3 -> DONE and ERR one edge after START, SS stays 3'b111, SCLK never toggles, DATA keeps its prior value.
4. Assert RST at cycle 40 of a transaction -> next edge: SS all 1, SCLK=0, BUSY=0, DATA=0; a new START then completes normally.
5. START pulsed again at cycle 10 of an active transaction with a different SS_ADDR -> ignored; single DONE at 137 with the original slave's data.
6. DATA_WIDTH=16, CLK_DIV=1, mode 1, slave returns 16'hDC3B -> DATA=16'hDC3B, DONE at edge 1*(2*24+2)+1 = 51.

Source files
------------

// File: rtl/spi_master_multimode.sv
// spi_master_multimode: address-then-read SPI master with START/BUSY/DONE handshake, CLK_DIV divider, CPOL/CPHA modes, out-of-range select ERR
module spi_master_multimode #(
  parameter int N_SS          = 4,
  parameter int SS_ADDR_WIDTH = 2,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [SS_ADDR_WIDTH-1:0] SS_ADDR,
  input  logic [ADDR_WIDTH-1:0]    DATA_ADDR,
  input  logic                     CPOL,
  input  logic                     CPHA,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic [DATA_WIDTH-1:0]    DATA,
  output logic                     SCLK,
  output logic                     MOSI,
  input  logic                     MISO,
  output logic [N_SS-1:0]          SS
);
  localparam int N  = ADDR_WIDTH + DATA_WIDTH;
  localparam int EW = $clog2(2 * N + 1);
  localparam int CW = $clog2(CLK_DIV + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] div_cnt;
  logic [EW-1:0] edge_cnt, edge_n;
  logic [N-1:0] tx;
  logic [DATA_WIDTH-1:0] rx, data_r;
  logic [SS_ADDR_WIDTH-1:0] sel;
  logic cpha, sclk_r, err_r, tick, bad, toggle, sample, active, last;
  always_comb begin
    tick    = div_cnt == CW'(CLK_DIV - 1);
    bad     = 32'(SS_ADDR) >= N_SS;
    edge_n  = edge_cnt + EW'(1);
    last    = edge_cnt == EW'(2 * N);
    active  = state == SETUP || state == SHIFT || state == HOLD;
    toggle  = tick && (state == SETUP || (state == SHIFT && !last));
    sample  = edge_n[0] ^ cpha;
    state_n = state == IDLE  ? (START ? (bad ? FIN : SETUP) : IDLE) :
              state == SETUP ? (tick ? SHIFT : SETUP) :
              state == SHIFT ? (tick && last ? HOLD : SHIFT) :
              state == HOLD  ? (tick ? FIN : HOLD) : IDLE;
  end
  assign BUSY = state != IDLE;
  assign DONE = state == FIN;
  assign ERR  = err_r;
  assign DATA = data_r;
  assign SCLK = sclk_r;
  assign MOSI = (state == SETUP || state == SHIFT) & tx[N-1];
  assign SS   = active ? ~(N_SS'(1) << sel) : '1;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx       <= '0;
      rx       <= '0;
      sel      <= '0;
      cpha     <= 1'b0;
      sclk_r   <= 1'b0;
      err_r    <= 1'b0;
      data_r   <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= (active && !tick) ? div_cnt + CW'(1) : '0;
      if (state == IDLE && START) begin
        sel      <= SS_ADDR;
        cpha     <= CPHA;
        sclk_r   <= CPOL;
        err_r    <= bad;
        tx       <= {DATA_ADDR, {DATA_WIDTH{1'b0}}};
        edge_cnt <= '0;
      end
      // odd edges are leading edges; the first leading edge never advances MOSI
      if (toggle) begin
        sclk_r   <= ~sclk_r;
        edge_cnt <= edge_n;
        if (sample) rx <= {rx[DATA_WIDTH-2:0], MISO};
        else if (edge_n != EW'(1)) tx <= tx << 1;
      end
      if (state == HOLD && tick) data_r <= rx;
    end
  end
endmodule
